// File: rtl/icu_pkg.sv
// ----------------------------------------------------------------------------
// icu_pkg
// Shared definitions for the wide_icu instruction control unit.
//   - 4-bit opcode constants (OP_*)
//   - state_t : two-state sequencer type (EXEC / SKIP)
// No ports; imported by icu_lu and wide_icu.
// ----------------------------------------------------------------------------
package icu_pkg;

    localparam logic [3:0] OP_NOPO = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_LDC  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_ANDC = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_ORC  = 4'h6;
    localparam logic [3:0] OP_XNOR = 4'h7;
    localparam logic [3:0] OP_STO  = 4'h8;
    localparam logic [3:0] OP_STOC = 4'h9;
    localparam logic [3:0] OP_IEN  = 4'hA;
    localparam logic [3:0] OP_OEN  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RTN  = 4'hD;
    localparam logic [3:0] OP_SKZ  = 4'hE;
    localparam logic [3:0] OP_NOPF = 4'hF;

    typedef enum logic {
        ST_EXEC = 1'b0,
        ST_SKIP = 1'b1
    } state_t;

endpackage

// File: rtl/icu_lu.sv
// ----------------------------------------------------------------------------
// icu_lu
// Combinational logic unit: computes the next result-register value from
// the opcode, the current result register and the effective operand.
// Opcodes that are not logic operations leave the register unchanged.
// Ports:
//   op      in  [3:0]        opcode
//   rr      in  [WIDTH-1:0]  current result register
//   d       in  [WIDTH-1:0]  effective (input-enable masked) operand
//   rr_next out [WIDTH-1:0]  next result register value
// ----------------------------------------------------------------------------
module icu_lu
    import icu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] rr_next
);

    always_comb begin
        rr_next = rr;
        case (op)
            OP_LD:   rr_next = d;
            OP_LDC:  rr_next = ~d;
            OP_AND:  rr_next = rr & d;
            OP_ANDC: rr_next = rr & ~d;
            OP_OR:   rr_next = rr | d;
            OP_ORC:  rr_next = rr | ~d;
            OP_XNOR: rr_next = ~(rr ^ d);
            default: rr_next = rr;
        endcase
    end

endmodule

// File: rtl/wide_icu.sv
// ----------------------------------------------------------------------------
// wide_icu
// WIDTH-bit one-bit-style industrial control unit. Every rising edge samples
// a 4-bit opcode; logic ops update the result register, STO/STOC emit a
// one-cycle store strobe, IEN/OEN load the enable registers, and JMP/RTN/
// NOPO/NOPF produce one-cycle pulses. RTN (and a taken SKZ) makes the next
// sampled opcode a no-op. All outputs are registered.
//
// Configuration macro: WIDE_ICU_SKZ_EN
//   defined   -> SKZ skips the next opcode when rr == 0
//   undefined -> opcode E behaves like NOPF (flagf pulse, never skips)
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous reset, active-low
//   I       in   [3:0] opcode
//   data    in   [WIDTH-1:0] operand word
//   write   out  one-cycle store strobe
//   result  out  [WIDTH-1:0] stored word (valid with write, held otherwise)
//   rr      out  [WIDTH-1:0] result register
//   ien     out  input-enable register
//   oen     out  output-enable register
//   jmp, rtn, flag0, flagf  out  one-cycle opcode pulses
// ----------------------------------------------------------------------------
module wide_icu
    import icu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter bit RST_IEN = 1'b1,
    parameter bit RST_OEN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       I,
    input  logic [WIDTH-1:0] data,
    output logic             write,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] rr,
    output logic             ien,
    output logic             oen,
    output logic             jmp,
    output logic             rtn,
    output logic             flag0,
    output logic             flagf
);

    state_t           state;
    state_t           state_next;
    logic             exec;
    logic             skz_taken;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] rr_next;

    assign exec = (state == ST_EXEC);
    assign d    = ien ? data : '0;

`ifdef WIDE_ICU_SKZ_EN
    assign skz_taken = (I == OP_SKZ) && (rr == '0);
`else
    assign skz_taken = 1'b0;
`endif

    icu_lu #(
        .WIDTH (WIDTH)
    ) u_lu (
        .op      (I),
        .rr      (rr),
        .d       (d),
        .rr_next (rr_next)
    );

    // Sequencer: a skip lasts exactly one sampled opcode.
    always_comb begin
        state_next = state;
        case (state)
            ST_EXEC: begin
                if ((I == OP_RTN) || skz_taken) begin
                    state_next = ST_SKIP;
                end
            end
            ST_SKIP: state_next = ST_EXEC;
            default: state_next = ST_EXEC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_EXEC;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and strobes; nothing changes while skipping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr     <= '0;
            result <= '0;
            write  <= 1'b0;
            ien    <= RST_IEN;
            oen    <= RST_OEN;
            jmp    <= 1'b0;
            rtn    <= 1'b0;
            flag0  <= 1'b0;
            flagf  <= 1'b0;
        end else begin
            write <= 1'b0;
            jmp   <= 1'b0;
            rtn   <= 1'b0;
            flag0 <= 1'b0;
            flagf <= 1'b0;
            if (exec) begin
                rr <= rr_next;
                case (I)
                    OP_NOPO: flag0 <= 1'b1;
                    OP_STO: begin
                        if (oen) begin
                            write  <= 1'b1;
                            result <= rr;
                        end
                    end
                    OP_STOC: begin
                        if (oen) begin
                            write  <= 1'b1;
                            result <= ~rr;
                        end
                    end
                    // Enable loads use the raw data bit, not the masked operand.
                    OP_IEN:  ien <= data[0];
                    OP_OEN:  oen <= data[0];
                    OP_JMP:  jmp <= 1'b1;
                    OP_RTN:  rtn <= 1'b1;
`ifndef WIDE_ICU_SKZ_EN
                    OP_SKZ:  flagf <= 1'b1;
`endif
                    OP_NOPF: flagf <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wide_icu.sv
// ----------------------------------------------------------------------------
// tb_wide_icu
// Self-checking bench for wide_icu (WIDTH=8, default reset enables).
// Directed scenarios followed by randomized opcode/data streams with
// occasional resets, all compared against a behavioural reference model.
// ----------------------------------------------------------------------------
module tb_wide_icu;

    logic       clk;
    logic       rst;
    logic [3:0] I;
    logic [7:0] data;
    logic       write;
    logic [7:0] result;
    logic [7:0] rr;
    logic       ien;
    logic       oen;
    logic       jmp;
    logic       rtn;
    logic       flag0;
    logic       flagf;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [7:0] m_rr;
    logic [7:0] m_result;
    logic       m_write;
    logic       m_ien;
    logic       m_oen;
    logic       m_skip;
    logic [3:0] m_pulse;   // {jmp, rtn, flag0, flagf}

    wide_icu #(
        .WIDTH   (8),
        .RST_IEN (1'b1),
        .RST_OEN (1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .I      (I),
        .data   (data),
        .write  (write),
        .result (result),
        .rr     (rr),
        .ien    (ien),
        .oen    (oen),
        .jmp    (jmp),
        .rtn    (rtn),
        .flag0  (flag0),
        .flagf  (flagf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rr"},     rr,     m_rr);
        check({tag, ".write"},  write,  m_write);
        check({tag, ".result"}, result, m_result);
        check({tag, ".ien"},    ien,    m_ien);
        check({tag, ".oen"},    oen,    m_oen);
        check({tag, ".pulse"},  {jmp, rtn, flag0, flagf}, m_pulse);
    endtask

    // Behavioural model of one edge with rst high.
    task automatic model_step(input logic [3:0] op, input logic [7:0] dat);
        logic [7:0] opd;
        logic [7:0] old_rr;
        m_write = 1'b0;
        m_pulse = 4'b0000;
        if (m_skip) begin
            m_skip = 1'b0;
            return;
        end
        opd    = m_ien ? dat : 8'h00;
        old_rr = m_rr;
        case (op)
            4'h0: m_pulse[1] = 1'b1;
            4'h1: m_rr = opd;
            4'h2: m_rr = ~opd;
            4'h3: m_rr = old_rr & opd;
            4'h4: m_rr = old_rr & ~opd;
            4'h5: m_rr = old_rr | opd;
            4'h6: m_rr = old_rr | ~opd;
            4'h7: m_rr = ~(old_rr ^ opd);
            4'h8: if (m_oen) begin m_write = 1'b1; m_result = old_rr;  end
            4'h9: if (m_oen) begin m_write = 1'b1; m_result = ~old_rr; end
            4'hA: m_ien = dat[0];
            4'hB: m_oen = dat[0];
            4'hC: m_pulse[3] = 1'b1;
            4'hD: begin m_pulse[2] = 1'b1; m_skip = 1'b1; end
            4'hE: begin
`ifdef WIDE_ICU_SKZ_EN
                m_skip = (old_rr == 8'h00);
`else
                m_pulse[0] = 1'b1;
`endif
            end
            default: m_pulse[0] = 1'b1;
        endcase
    endtask

    task automatic model_reset();
        m_rr     = 8'h00;
        m_result = 8'h00;
        m_write  = 1'b0;
        m_ien    = 1'b1;
        m_oen    = 1'b1;
        m_skip   = 1'b0;
        m_pulse  = 4'b0000;
    endtask

    task automatic step(input string tag, input logic [3:0] op, input logic [7:0] dat);
        @(negedge clk);
        rst  = 1'b1;
        I    = op;
        data = dat;
        @(posedge clk);
        model_step(op, dat);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst  = 1'b0;
        I    = 4'($urandom_range(0, 15));
        data = 8'($urandom);
        @(posedge clk);
        model_reset();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst  = 1'b0;
        I    = 4'h0;
        data = 8'h00;
        model_reset();

        do_reset("reset");
        check("reset.rr_const", rr, 8'h00);

        // load / store
        step("ld_a5", 4'h1, 8'hA5);
        check("ld_a5.const", rr, 8'hA5);
        step("sto_a5", 4'h8, 8'h00);
        check("sto_a5.write", write, 1'b1);
        check("sto_a5.result", result, 8'hA5);

        // logic ops
        step("ld_f0", 4'h1, 8'hF0);
        step("and_3c", 4'h3, 8'h3C);
        check("and_3c.const", rr, 8'h30);
        step("orc_ff", 4'h6, 8'hFF);
        check("orc_ff.const", rr, 8'h30);
        step("xnor_30", 4'h7, 8'h30);
        check("xnor_30.const", rr, 8'hFF);

        // output enable and complemented store
        step("oen0", 4'hB, 8'h00);
        step("sto_oen0", 4'h8, 8'h00);
        check("sto_oen0.write", write, 1'b0);
        step("oen1", 4'hB, 8'h01);
        step("ld_0f", 4'h1, 8'h0F);
        step("stoc_0f", 4'h9, 8'h00);
        check("stoc_0f.result", result, 8'hF0);

        // back-to-back stores
        step("sto_b2b0", 4'h8, 8'h00);
        step("ld_3c", 4'h1, 8'h3C);
        step("sto_b2b1", 4'h8, 8'h00);
        step("stoc_b2b2", 4'h9, 8'h00);

        // input enable masking
        step("ien0", 4'hA, 8'h00);
        step("ld_masked", 4'h1, 8'h55);
        check("ld_masked.const", rr, 8'h00);
        step("ien1", 4'hA, 8'h01);
        step("ld_55", 4'h1, 8'h55);
        check("ld_55.const", rr, 8'h55);

        // SKZ with rr == 0 and rr != 0
        step("ld_00", 4'h1, 8'h00);
        step("skz_z", 4'hE, 8'h00);
        step("ld_11a", 4'h1, 8'h11);
        step("ld_22a", 4'h1, 8'h22);
        check("skz_z.const", rr, 8'h22);
        step("skz_nz", 4'hE, 8'h00);
        step("ld_11b", 4'h1, 8'h11);
        check("skz_nz.const", rr, 8'h11);
        step("ld_22b", 4'h1, 8'h22);

        // RTN skips the following store; pulses
        step("rtn", 4'hD, 8'h00);
        check("rtn.pulse_const", rtn, 1'b1);
        step("sto_skipped", 4'h8, 8'h00);
        check("sto_skipped.write", write, 1'b0);
        step("jmp", 4'hC, 8'h00);
        step("nopo", 4'h0, 8'h00);
        step("nopf", 4'hF, 8'h00);

        // reset during SKIP cancels the skip
        step("rtn2", 4'hD, 8'h00);
        do_reset("reset_skip");
        step("ld_77", 4'h1, 8'h77);
        check("ld_77.const", rr, 8'h77);

        // randomized stream
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset("rnd_reset");
            end else begin
                logic [3:0] op;
                logic [7:0] dv;
                op = 4'($urandom_range(0, 15));
                dv = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                // keep enables mostly on so the logic ops see real operands
                if ((op == 4'hA || op == 4'hB) && $urandom_range(0, 2) != 0) dv[0] = 1'b1;
                step("rnd", op, dv);
            end
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wide_icu.md
WIDE_ICU -- requirements
Module: wide_icu

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data/result word width in bits (legal range 1..32).
REQ-002 SHALL provide parameter RST_IEN, default 1, reset value of the input-enable register.
REQ-003 SHALL provide parameter RST_OEN, default 1, reset value of the output-enable register.
REQ-004 Port: clk  input  1  sole clock, rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-low.
REQ-006 Port: I  input  4  opcode, sampled every rising edge.
REQ-007 Port: data  input  WIDTH  operand word.
REQ-008 Port: write  output  1  one-cycle store strobe.
REQ-009 Port: result  output  WIDTH  stored word, valid when write=1.
REQ-010 Port: rr  output  WIDTH  current result register.
REQ-011 Port: ien, oen  output  1 each  current enable registers.
REQ-012 Port: jmp, rtn, flag0, flagf  output  1 each  one-cycle opcode pulses.

Function
REQ-013 Opcodes SHALL be: 0 NOPO, 1 LD, 2 LDC, 3 AND, 4 ANDC, 5 OR, 6 ORC, 7 XNOR, 8 STO, 9 STOC, A IEN, B OEN, C JMP, D RTN, E SKZ, F NOPF.
REQ-014 Effective operand d SHALL be data when ien=1, else all-zero.
REQ-015 Logic ops SHALL be bitwise over WIDTH: LD rr<=d; LDC rr<=~d; AND rr<=rr&d; ANDC rr<=rr&~d; OR rr<=rr|d; ORC rr<=rr|~d; XNOR rr<=~(rr^d).
REQ-016 STO SHALL, when oen=1, drive write=1 and result=rr (pre-edge value) for exactly the cycle after the edge; STOC likewise with result=~rr; when oen=0, write SHALL stay 0 and result SHALL hold its last value.
REQ-017 IEN SHALL load ien<=data[0]; OEN SHALL load oen<=data[0]; data[0] is used unmasked regardless of ien.
REQ-018 JMP, NOPO, NOPF SHALL pulse jmp, flag0, flagf respectively for one cycle; rr unchanged.
REQ-019 RTN SHALL pulse rtn for one cycle and set the skip state.
REQ-020 SKZ SHALL set the skip state iff rr==0 at the edge.
REQ-021 Two-state FSM: EXEC, SKIP; EXEC->SKIP on RTN or taken SKZ; SKIP->EXEC unconditionally after one cycle.
REQ-022 In SKIP the sampled opcode SHALL have no effect: no rr/ien/oen update, no write, no pulses.
REQ-023 All outputs SHALL be registered; latency opcode-edge to effect is one cycle.
REQ-024 Back-to-back STO SHALL produce write held high for consecutive cycles with per-cycle result.

Reset
REQ-025 While rst=0 at an edge: rr=0, result=0, write=0, all pulses=0, ien=RST_IEN, oen=RST_OEN, state=EXEC.
REQ-026 Reset mid-SKIP SHALL cancel the skip; first post-reset opcode executes.

Configuration
REQ-027 Macro WIDE_ICU_SKZ_EN: defined -> SKZ per REQ-020; undefined -> opcode E never sets skip and pulses flagf like NOPF; RTN skip is unaffected.

Structure
REQ-028 Package icu_pkg SHALL hold opcode constants and the FSM state typedef.
REQ-029 Combinational sub-module icu_lu (WIDTH-parametrised) SHALL compute the next rr from opcode, rr, d; FSM, enables, strobes stay in wide_icu.

Verification
REQ-030 Reset, then LD data=8'hA5 -> rr=8'hA5; STO -> next cycle write=1, result=8'hA5.
REQ-031 rr=8'hF0; AND data=8'h3C -> rr=8'h30; ORC data=8'hFF -> rr=8'h30; XNOR data=8'h30 -> rr=8'hFF.
REQ-032 OEN data=0 then STO -> write=0; OEN data=1, STOC with rr=8'h0F -> write=1, result=8'hF0.
REQ-033 IEN data=0 then LD data=8'h55 -> rr=8'h00; IEN data=1, LD data=8'h55 -> rr=8'h55.
REQ-034 rr=0, SKZ then LD 8'h11 then LD 8'h22 -> first LD skipped, rr=8'h22; with rr!=0 -> rr=8'h11 then 8'h22; macro undefined -> no skip, flagf pulse.
REQ-035 RTN then STO -> rtn pulse, no write; rst low during SKIP then LD 8'h77 -> rr=8'h77.
